// File: rtl/q2_ctrl_alu.sv
// -----------------------------------------------------------------------------
// q2_ctrl_alu
//   Sequencer, bit-serial ALU and push-button input port of the Q2 12-bit
//   bit-serial CPU. An instruction word read from the data bus is decoded into
//   a 3-bit opcode and a deref bit. The FSM then steps FETCH / DEREF / EXEC and
//   drives the strobes of the external 12-bit slice datapath (A, X, P, memory).
//   This block also holds the carry flag F, the run/halt latch and the button
//   debouncers.
//
// Ports
//   clk, rst            single clock; asynchronous active-low reset
//   dbus[11:0]          instruction/operand from RAM (or buttons during IN)
//   a0, x0              LSBs of the A and X shift registers
//   x_is_pm1            datapath compare X == P-1 (detects "jmp $")
//   start_sw, stop_sw,
//   incp_sw, dep_sw     front-panel switches (synchronous levels)
//   btn[3:0]            raw push buttons (asynchronous, bouncy)
//   io_rd               IO read strobe; drives btn_oe
//   wro ... wrf         one-cycle active-high datapath strobes
//   xhin_* / xlin_*     load source select for X[11:7] / X[6:0]
//   alu_out, alu_cout   serial result bit and carry out of the current bit
//   f, run              carry flag and running status
//   btn_data, btn_oe    {8'b0, debounced buttons} and its output enable
// -----------------------------------------------------------------------------
module q2_ctrl_alu #(
  parameter int WIDTH    = 12,
  parameter int DEBOUNCE = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] dbus,
  input  logic        a0,
  input  logic        x0,
  input  logic        x_is_pm1,
  input  logic        start_sw,
  input  logic        stop_sw,
  input  logic        incp_sw,
  input  logic        dep_sw,
  input  logic [3:0]  btn,
  input  logic        io_rd,
  output logic        wro,
  output logic        wra,
  output logic        rda,
  output logic        wrx,
  output logic        rdx,
  output logic        wrp,
  output logic        rdp,
  output logic        incp,
  output logic        wrm,
  output logic        io,
  output logic        wrf,
  output logic        xhin_shift,
  output logic        xhin_p,
  output logic        xhin_zero,
  output logic        xhin_dbus,
  output logic        xlin_shift,
  output logic        xlin_dbus,
  output logic        alu_out,
  output logic        alu_cout,
  output logic        f,
  output logic        run,
  output logic [11:0] btn_data,
  output logic        btn_oe
);

  typedef enum logic [2:0] {
    OP_LEA = 3'd0,
    OP_LD  = 3'd1,
    OP_ADD = 3'd2,
    OP_NOR = 3'd3,
    OP_ST  = 3'd4,
    OP_JC  = 3'd5,
    OP_JMP = 3'd6,
    OP_IN  = 3'd7
  } op_e;

  // S_LOAD is the X <= mem[X] operand fetch shared by LD/ADD/NOR.
  // S_PWRM / S_PINCP are the front-panel deposit / increment pulses.
  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DEREF,
    S_LOAD,
    S_SHIFT,
    S_ST,
    S_JC,
    S_JMP,
    S_IN,
    S_PWRM,
    S_PINCP
  } state_e;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

  state_e           state;
  op_e              opcode;
  logic             deref;
  logic [CNT_W-1:0] bit_cnt;
  logic             start_q, incp_q, dep_q;
  logic             start_rise, incp_rise, dep_rise;
  logic             run_nxt;
  state_e           after_exec;
  op_e              dbus_op;

  assign start_rise = start_sw & ~start_q;
  assign incp_rise  = incp_sw  & ~incp_q;
  assign dep_rise   = dep_sw   & ~dep_q;
  assign dbus_op    = op_e'(dbus[11:9]);

  // First EXEC state for a given opcode.
  function automatic state_e exec_entry(input op_e op);
    case (op)
      OP_LEA:                return S_SHIFT;
      OP_LD, OP_ADD, OP_NOR: return S_LOAD;
      OP_ST:                 return S_ST;
      OP_JC:                 return S_JC;
      OP_JMP:                return S_JMP;
      default:               return S_IN;
    endcase
  endfunction

  // Run latch: start only from IDLE with stop released; stop or a
  // self-jump ("jmp $") halts. The instruction in flight still completes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    run_nxt = run;
    if (state == S_IDLE && start_rise && !stop_sw) run_nxt = 1'b1;
    if (stop_sw)                                   run_nxt = 1'b0;
    if (state == S_JMP && x_is_pm1)                run_nxt = 1'b0;
  end

  assign after_exec = run_nxt ? S_FETCH : S_IDLE;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      opcode  <= OP_LEA;
      deref   <= 1'b0;
      bit_cnt <= '0;
      f       <= 1'b0;
      run     <= 1'b0;
      start_q <= 1'b0;
      incp_q  <= 1'b0;
      dep_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      start_q <= start_sw;
      incp_q  <= incp_sw;
      dep_q   <= dep_sw;
      run     <= run_nxt;
      if (wrf) f <= alu_cout;

      case (state)
        S_IDLE: begin
          if (start_rise && !stop_sw) state <= S_FETCH;
          else if (dep_rise)          state <= S_PWRM;
          else if (incp_rise)         state <= S_PINCP;
        end
        S_PWRM:  state <= S_PINCP;
        S_PINCP: state <= S_IDLE;
        S_FETCH: begin
          opcode <= dbus_op;
          deref  <= dbus[8];
          state  <= dbus[8] ? S_DEREF : exec_entry(dbus_op);
        end
        S_DEREF: state <= exec_entry(opcode);
        S_LOAD: begin
          // ADD starts its serial sum with a clear carry.
          if (opcode == OP_ADD) f <= 1'b0;
          bit_cnt <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            state   <= after_exec;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_ST, S_JC, S_JMP, S_IN: state <= after_exec;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath strobes, decoded from the current state
  // ---------------------------------------------------------------------------
  always_comb begin
    wro = 1'b0; wra = 1'b0; rda = 1'b0; wrx = 1'b0; rdx = 1'b0; wrp = 1'b0;
    rdp = 1'b0; incp = 1'b0; wrm = 1'b0; io = 1'b0; wrf = 1'b0;
    xhin_shift = 1'b0; xhin_p = 1'b0; xhin_zero = 1'b0; xhin_dbus = 1'b0;
    xlin_shift = 1'b0; xlin_dbus = 1'b0;
    case (state)
      S_FETCH: begin
        // X <= {page ? P[11:7] : 0, dbus[6:0]}; P advances past the word.
        rdp       = 1'b1;
        wro       = 1'b1;
        wrx       = 1'b1;
        xlin_dbus = 1'b1;
        xhin_p    = dbus[7];
        xhin_zero = ~dbus[7];
        incp      = 1'b1;
      end
      S_DEREF, S_LOAD: begin
        rdx       = 1'b1;
        wrx       = 1'b1;
        xhin_dbus = 1'b1;
        xlin_dbus = 1'b1;
      end
      S_SHIFT: begin
        wra        = 1'b1;
        wrx        = 1'b1;
        xhin_shift = 1'b1;
        xlin_shift = 1'b1;
        wrf        = (opcode == OP_ADD);
      end
      S_ST: begin
        rdx = 1'b1;
        rda = 1'b1;
        wrm = 1'b1;
      end
      S_JC: begin
        rdx = f;
        wrp = f;
      end
      S_JMP: begin
        rdx = 1'b1;
        wrp = 1'b1;
      end
      S_IN: begin
        io  = 1'b1;
        wra = 1'b1;
      end
      S_PWRM:  wrm  = 1'b1;
      S_PINCP: incp = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bit-serial ALU: one result bit per shift cycle, LSB first
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_out  = 1'b0;
    alu_cout = 1'b0;
    if (state == S_SHIFT) begin
      case (opcode)
        OP_ADD: begin
          alu_out  = a0 ^ x0 ^ f;
          alu_cout = (a0 & x0) | (a0 & f) | (x0 & f);
        end
        OP_NOR:  alu_out = ~(a0 | x0);
        default: alu_out = x0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Button port: 2-flop synchronizer, then a per-bit hold counter. A new level
  // is accepted only after it has held for DEBOUNCE consecutive cycles; any
  // return to the accepted level restarts the count.
  // ---------------------------------------------------------------------------
  logic [3:0]      btn_s1, btn_s2, btn_q;
  logic [DB_W-1:0] db_cnt [4];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_q  <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      for (int i = 0; i < 4; i++) begin
        if (btn_s2[i] == btn_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_q[i]  <= btn_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign btn_data = {8'b0, btn_q};
  assign btn_oe   = io_rd;

  // Address bits and the latched deref flag are consumed by the external
  // datapath / sequencing only; fold them here so they are visibly intentional.
  logic unused;
  assign unused = ^{dbus[6:0], deref};

endmodule

// File: tb/tb_q2_ctrl_alu.sv
// -----------------------------------------------------------------------------
// tb_q2_ctrl_alu
//   Self-checking bench for q2_ctrl_alu. A small behavioural model of the
//   external slice datapath (A, X, P, RAM) reacts to the DUT strobes, and each
//   scenario compares architectural results against plain arithmetic.
// -----------------------------------------------------------------------------
module tb_q2_ctrl_alu;

  localparam int DEBOUNCE = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] dbus;
  logic        a0, x0, x_is_pm1;
  logic        start_sw = 1'b0, stop_sw = 1'b0, incp_sw = 1'b0, dep_sw = 1'b0;
  logic [3:0]  btn = 4'h0;
  logic        io_rd;
  logic        wro, wra, rda, wrx, rdx, wrp, rdp, incp, wrm, io, wrf;
  logic        xhin_shift, xhin_p, xhin_zero, xhin_dbus, xlin_shift, xlin_dbus;
  logic        alu_out, alu_cout, f, run;
  logic [11:0] btn_data;
  logic        btn_oe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  q2_ctrl_alu #(.WIDTH(12), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst(rst), .dbus(dbus), .a0(a0), .x0(x0), .x_is_pm1(x_is_pm1),
    .start_sw(start_sw), .stop_sw(stop_sw), .incp_sw(incp_sw), .dep_sw(dep_sw),
    .btn(btn), .io_rd(io_rd),
    .wro(wro), .wra(wra), .rda(rda), .wrx(wrx), .rdx(rdx), .wrp(wrp), .rdp(rdp),
    .incp(incp), .wrm(wrm), .io(io), .wrf(wrf),
    .xhin_shift(xhin_shift), .xhin_p(xhin_p), .xhin_zero(xhin_zero),
    .xhin_dbus(xhin_dbus), .xlin_shift(xlin_shift), .xlin_dbus(xlin_dbus),
    .alu_out(alu_out), .alu_cout(alu_cout), .f(f), .run(run),
    .btn_data(btn_data), .btn_oe(btn_oe)
  );

  // Strobe vector, MSB first: wro wra rda wrx rdx wrp rdp incp wrm io wrf
  // xhin_shift xhin_p xhin_zero xhin_dbus xlin_shift xlin_dbus
  logic [16:0] strb;
  assign strb = {wro, wra, rda, wrx, rdx, wrp, rdp, incp, wrm, io, wrf,
                 xhin_shift, xhin_p, xhin_zero, xhin_dbus, xlin_shift, xlin_dbus};
  localparam logic [16:0] M_WRX   = 17'h02000;
  localparam logic [16:0] M_INCP  = 17'h00200;
  localparam logic [16:0] M_WRM   = 17'h00100;
  // FETCH of a page-0 word: wro, rdp, incp, xhin_zero, xlin_dbus
  localparam logic [16:0] M_FETCH = 17'h10609;

  // ---------------------------------------------------------------------------
  // Datapath environment model
  // ---------------------------------------------------------------------------
  logic [11:0] ra, rx, rp;
  logic [11:0] mem [0:4095];
  logic        env_load = 1'b0, env_we = 1'b0;
  logic [11:0] env_a = '0, env_x = '0, env_p = '0, env_addr = '0, env_data = '0;
  int          wra_cnt, wrp_cnt;
  logic [11:0] addr, x_shr;

  assign addr     = rdx ? rx : rp;
  assign io_rd    = io;
  assign dbus     = io_rd ? btn_data : mem[addr];
  assign a0       = ra[0];
  assign x0       = rx[0];
  assign x_is_pm1 = (rx == rp - 12'd1);
  assign x_shr    = {1'b0, rx[11:1]};

  always @(posedge clk) begin
    if (env_we) mem[env_addr] <= env_data;
    else if (wrm) mem[addr] <= ra;
    if (env_load) begin
      ra <= env_a; rx <= env_x; rp <= env_p;
      wra_cnt <= 0; wrp_cnt <= 0;
    end else begin
      if (wra) begin
        ra <= io ? dbus : {alu_out, ra[11:1]};
        wra_cnt <= wra_cnt + 1;
      end
      if (xhin_shift)     rx[11:7] <= x_shr[11:7];
      else if (xhin_p)    rx[11:7] <= rp[11:7];
      else if (xhin_zero) rx[11:7] <= 5'd0;
      else if (xhin_dbus) rx[11:7] <= dbus[11:7];
      if (xlin_shift)     rx[6:0] <= x_shr[6:0];
      else if (xlin_dbus) rx[6:0] <= dbus[6:0];
      if (wrp) begin
        rp <= rx;
        wrp_cnt <= wrp_cnt + 1;
      end else if (incp) begin
        rp <= rp + 12'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic env_set(input logic [11:0] a, input logic [11:0] x, input logic [11:0] p);
    env_a = a; env_x = x; env_p = p; env_load = 1'b1;
    @(negedge clk);
    env_load = 1'b0;
  endtask

  task automatic mem_wr(input logic [11:0] ad, input logic [11:0] d);
    env_addr = ad; env_data = d; env_we = 1'b1;
    @(negedge clk);
    env_we = 1'b0;
  endtask

  task automatic run_prog(input logic [11:0] a, input logic [11:0] p, input int budget,
                          output bit halted, output logic [16:0] first_strb);
    env_set(a, 12'h000, p);
    start_sw = 1'b1;
    @(negedge clk);
    start_sw = 1'b0;
    first_strb = strb;
    halted = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!run) begin
        halted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (strb !== 17'h0) begin bad++; $display("FAIL reset_strobes got=%h want=0", strb); end
    total++; if (run !== 1'b0) begin bad++; $display("FAIL reset_run got=%b want=0", run); end
    total++; if (f !== 1'b0) begin bad++; $display("FAIL reset_f got=%b want=0", f); end
    total++; if (btn_data !== 12'h000) begin bad++; $display("FAIL reset_btn got=%h want=000", btn_data); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (strb !== 17'h0 || run !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset strb=%h run=%b want 0/0", strb, run);
    end
  endtask

  task automatic test_panel();
    dep_sw = 1'b1;
    @(negedge clk);
    total++; if (strb !== M_WRM) begin bad++; $display("FAIL dep_cycle1 got=%h want=%h", strb, M_WRM); end
    @(negedge clk);
    total++; if (strb !== M_INCP) begin bad++; $display("FAIL dep_cycle2 got=%h want=%h", strb, M_INCP); end
    @(negedge clk);
    total++; if (strb !== 17'h0) begin bad++; $display("FAIL dep_cycle3 got=%h want=0", strb); end
    dep_sw = 1'b0;
    @(negedge clk);
    incp_sw = 1'b1;
    @(negedge clk);
    total++; if (strb !== M_INCP) begin bad++; $display("FAIL incp_cycle1 got=%h want=%h", strb, M_INCP); end
    @(negedge clk);
    total++; if (strb !== 17'h0) begin bad++; $display("FAIL incp_cycle2 got=%h want=0", strb); end
    incp_sw = 1'b0;
    @(negedge clk);
    total++; if (run !== 1'b0) begin bad++; $display("FAIL panel_run got=%b want=0", run); end
  endtask

  task automatic test_lea_ld();
    bit          h;
    logic [16:0] fs;
    logic [11:0] ptr, v;
    mem_wr(12'h011, 12'hC11);            // JMP $
    // LEA direct: A <= 0x040, check the FETCH strobe pattern too
    mem_wr(12'h010, 12'h040);
    run_prog(12'h5A5, 12'h010, 100, h, fs);
    total++; if ((fs & ~M_WRX) !== M_FETCH) begin bad++; $display("FAIL fetch_strobes got=%h want=%h", fs & ~M_WRX, M_FETCH); end
    total++; if (!h || ra !== 12'h040) begin bad++; $display("FAIL lea_direct halted=%b got=%h want=040", h, ra); end
    for (int i = 0; i < 3; i++) begin
      ptr = 12'($urandom_range(12'h100, 12'hFFF));
      v   = 12'($urandom());
      mem_wr(12'h040, ptr);
      mem_wr(ptr, v);
      mem_wr(12'h010, 12'h140);          // LEA deref 0x40
      run_prog(12'h000, 12'h010, 100, h, fs);
      total++; if (!h || ra !== ptr) begin bad++; $display("FAIL lea_deref halted=%b got=%h want=%h", h, ra, ptr); end
      mem_wr(12'h010, 12'h340);          // LD deref 0x40
      run_prog(12'h000, 12'h010, 100, h, fs);
      total++; if (!h || ra !== v) begin bad++; $display("FAIL ld_deref halted=%b got=%h want=%h", h, ra, v); end
      mem_wr(12'h010, 12'h240);          // LD direct 0x40
      run_prog(12'h000, 12'h010, 100, h, fs);
      total++; if (!h || ra !== ptr) begin bad++; $display("FAIL ld_direct halted=%b got=%h want=%h", h, ra, ptr); end
    end
    // Page-relative LEA from page 1: X = {P[11:7], 0x45} = 0x0C5
    mem_wr(12'h090, 12'h0C5);
    mem_wr(12'h091, 12'hC91);
    run_prog(12'h000, 12'h090, 100, h, fs);
    total++; if (!h || ra !== 12'h0C5) begin bad++; $display("FAIL lea_page halted=%b got=%h want=0C5", h, ra); end
  endtask

  task automatic test_add();
    bit          h;
    logic [16:0] fs;
    logic [11:0] a, m;
    logic [12:0] sum;
    mem_wr(12'h010, 12'h440);            // ADD 0x40
    mem_wr(12'h011, 12'hC11);
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin a = 12'hFFF; m = 12'h001; end
        1: begin a = 12'hFFF; m = 12'h000; end
        2: begin a = 12'h800; m = 12'h800; end
        default: begin a = 12'($urandom()); m = 12'($urandom()); end
      endcase
      mem_wr(12'h040, m);
      run_prog(a, 12'h010, 100, h, fs);
      sum = {1'b0, a} + {1'b0, m};
      total++; if (!h || ra !== sum[11:0]) begin bad++; $display("FAIL add_sum %h+%h halted=%b got=%h want=%h", a, m, h, ra, sum[11:0]); end
      total++; if (f !== sum[12]) begin bad++; $display("FAIL add_carry %h+%h got=%b want=%b", a, m, f, sum[12]); end
    end
  endtask

  task automatic test_nor();
    bit          h;
    logic [16:0] fs;
    logic [11:0] a, m;
    mem_wr(12'h010, 12'h640);            // NOR 0x40
    mem_wr(12'h011, 12'hC11);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin a = 12'h0F0; m = 12'h00F; end
      else begin a = 12'($urandom()); m = 12'($urandom()); end
      mem_wr(12'h040, m);
      run_prog(a, 12'h010, 100, h, fs);
      total++; if (!h || ra !== ~(a | m)) begin bad++; $display("FAIL nor %h,%h halted=%b got=%h want=%h", a, m, h, ra, ~(a | m)); end
      total++; if (wra_cnt !== 12) begin bad++; $display("FAIL nor_wra_count got=%0d want=12", wra_cnt); end
    end
  endtask

  task automatic test_st();
    bit          h;
    logic [16:0] fs;
    logic [11:0] a;
    a = 12'($urandom());
    mem_wr(12'h050, ~a);
    mem_wr(12'h010, 12'h850);            // ST 0x50
    mem_wr(12'h011, 12'hC11);
    run_prog(a, 12'h010, 100, h, fs);
    total++; if (!h || mem[12'h050] !== a) begin bad++; $display("FAIL st halted=%b got=%h want=%h", h, mem[12'h050], a); end
  endtask

  task automatic test_jc();
    bit          h;
    logic [16:0] fs;
    mem_wr(12'h010, 12'h440);            // ADD 0x40
    mem_wr(12'h011, 12'hA20);            // JC 0x20
    mem_wr(12'h012, 12'hC12);            // not taken: halt here
    mem_wr(12'h020, 12'hC20);            // taken: halt here
    mem_wr(12'h040, 12'h001);
    run_prog(12'hFFF, 12'h010, 100, h, fs);
    total++; if (!h || rp !== 12'h020) begin bad++; $display("FAIL jc_taken halted=%b P=%h want=020", h, rp); end
    mem_wr(12'h040, 12'h000);
    run_prog(12'hFFF, 12'h010, 100, h, fs);
    total++; if (!h || rp !== 12'h012) begin bad++; $display("FAIL jc_not_taken halted=%b P=%h want=012", h, rp); end
  endtask

  task automatic test_jmp_halt();
    bit          h;
    logic [16:0] fs;
    mem_wr(12'h085, 12'hC85);            // JMP $ via page bit
    run_prog(12'h000, 12'h085, 20, h, fs);
    total++; if (!h || wrp_cnt !== 1) begin bad++; $display("FAIL jmp_self halted=%b wrp=%0d want 1/1", h, wrp_cnt); end
    total++; if (rp !== 12'h085) begin bad++; $display("FAIL jmp_self_p got=%h want=085", rp); end
    total++; if (strb !== 17'h0 || run !== 1'b0) begin bad++; $display("FAIL jmp_self_idle strb=%h run=%b", strb, run); end
  endtask

  // Accepted DEBOUNCE cycles after the last edge, plus the 2-flop synchronizer.
  task automatic test_debounce();
    bit seen;
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      @(negedge clk);
    end
    total++; if (btn_data !== 12'h000) begin bad++; $display("FAIL bounce_held got=%h want=000", btn_data); end
    btn = 4'b0100;
    repeat (DEBOUNCE - 1) @(negedge clk);
    total++; if (btn_data !== 12'h000) begin bad++; $display("FAIL debounce_early got=%h want=000", btn_data); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (btn_data === 12'h004) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL debounce_accept got=%h want=004", btn_data); end
    btn = 4'b0000;
    repeat (DEBOUNCE + 4) @(negedge clk);
    total++; if (btn_data !== 12'h000) begin bad++; $display("FAIL debounce_release got=%h want=000", btn_data); end
  endtask

  task automatic test_in();
    bit          h;
    logic [16:0] fs;
    btn = 4'b1011;
    repeat (DEBOUNCE + 4) @(negedge clk);
    mem_wr(12'h010, 12'hE00);            // IN
    mem_wr(12'h011, 12'hC11);
    run_prog(12'h777, 12'h010, 100, h, fs);
    total++; if (!h || ra !== 12'h00B) begin bad++; $display("FAIL in halted=%b got=%h want=00B", h, ra); end
    total++; if (btn_oe !== 1'b0) begin bad++; $display("FAIL btn_oe_idle got=%b want=0", btn_oe); end
    btn = 4'b0000;
    repeat (DEBOUNCE + 4) @(negedge clk);
  endtask

  task automatic test_stop();
    bit idle;
    mem_wr(12'h030, 12'h030);            // LEA 0x30
    mem_wr(12'h031, 12'hC30);            // JMP 0x30 (loop, not self)
    env_set(12'h000, 12'h000, 12'h030);
    start_sw = 1'b1;
    @(negedge clk);
    start_sw = 1'b0;
    repeat (30) @(negedge clk);
    total++; if (run !== 1'b1) begin bad++; $display("FAIL loop_running got=%b want=1", run); end
    stop_sw = 1'b1;
    @(negedge clk);
    total++; if (run !== 1'b0) begin bad++; $display("FAIL stop_run got=%b want=0", run); end
    idle = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (strb === 17'h0) begin
        idle = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    total++; if (!idle || strb !== 17'h0) begin bad++; $display("FAIL stop_idle reached=%b strb=%h", idle, strb); end
    // start is ignored while stop is held
    start_sw = 1'b1;
    @(negedge clk);
    start_sw = 1'b0;
    @(negedge clk);
    total++; if (run !== 1'b0 || strb !== 17'h0) begin bad++; $display("FAIL start_blocked run=%b strb=%h", run, strb); end
    stop_sw = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_add();
    int shifts;
    mem_wr(12'h010, 12'h440);
    mem_wr(12'h011, 12'hC11);
    mem_wr(12'h040, 12'hFFF);
    env_set(12'hFFF, 12'h000, 12'h010);
    start_sw = 1'b1;
    @(negedge clk);
    start_sw = 1'b0;
    shifts = 0;
    for (int i = 0; i < 40; i++) begin
      if (wra === 1'b1) shifts++;
      if (shifts == 5) break;
      @(negedge clk);
    end
    total++; if (shifts != 5 || f !== 1'b1) begin bad++; $display("FAIL mid_add_reached shifts=%0d f=%b want 5/1", shifts, f); end
    rst = 1'b0;
    #1;
    total++; if (strb !== 17'h0 || run !== 1'b0 || f !== 1'b0) begin
      bad++; $display("FAIL mid_add_reset strb=%h run=%b f=%b want 0/0/0", strb, run, f);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (strb !== 17'h0 || run !== 1'b0) begin bad++; $display("FAIL post_reset_idle strb=%h run=%b", strb, run); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_panel();
    test_lea_ld();
    test_add();
    test_nor();
    test_st();
    test_jc();
    test_jmp_halt();
    test_debounce();
    test_in();
    test_stop();
    test_reset_mid_add();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
